// File: rtl/vec_wb_arbiter.sv
// Round-robin arbiter sharing the vec_ram write port between NUM_REQ writeback sources.
// Define VEC_WB_HAZARD_EN to enable read-after-write hazard flags on the two read ports.
module vec_wb_arbiter #(
    parameter int VEC_SIZE        = 32,
    parameter int VEC_INDEX_WIDTH = 3,
    parameter int NUM_REQ         = 2
) (
    input  logic                                                i_clk,
    input  logic                                                i_rst,
    input  logic                                                i_hold,
    input  logic [NUM_REQ-1:0]                                  i_req_valid,
    output logic [NUM_REQ-1:0]                                  o_req_ready,
    input  logic [NUM_REQ-1:0][VEC_INDEX_WIDTH-1:0]             i_req_addr,
    input  logic [NUM_REQ-1:0][15:0][VEC_SIZE-1:0]              i_req_data,
    output logic                                                o_write_enable,
    output logic [VEC_INDEX_WIDTH-1:0]                          o_write_addr,
    output logic [15:0][VEC_SIZE-1:0]                           o_write_data,
    output logic [$clog2(NUM_REQ)-1:0]                          o_grant_id,
    input  logic [VEC_INDEX_WIDTH-1:0]                          i_rd_addr_a,
    input  logic [VEC_INDEX_WIDTH-1:0]                          i_rd_addr_b,
    output logic                                                o_hazard_a,
    output logic                                                o_hazard_b
);

    localparam int GID_W = $clog2(NUM_REQ);

    // Handshake: requester r transfers at a posedge where i_req_valid[r] && o_req_ready[r];
    // it keeps addr/data stable and valid asserted until that edge.
    logic [GID_W-1:0]           ptr_q, ptr_d;
    logic                       we_q, we_d;
    logic [VEC_INDEX_WIDTH-1:0] addr_q, addr_d;
    logic [15:0][VEC_SIZE-1:0]  data_q, data_d;
    logic [GID_W-1:0]           gid_q, gid_d;

    logic [GID_W-1:0]           win;
    logic                       found;
    logic                       grant;
    logic [GID_W:0]             idx;

    // Scan from the pointer, wrapping once; the first valid requester wins.
    always_comb begin
        win   = '0;
        found = 1'b0;
        idx   = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            idx = {1'b0, ptr_q} + (GID_W+1)'(k);
            if (idx >= (GID_W+1)'(NUM_REQ)) begin
                idx = idx - (GID_W+1)'(NUM_REQ);
            end
            if (!found && i_req_valid[idx[GID_W-1:0]]) begin
                found = 1'b1;
                win   = idx[GID_W-1:0];
            end
        end
    end

    assign grant       = found && !i_hold && i_rst;
    assign o_req_ready = grant ? (NUM_REQ'(1) << win) : '0;

    always_comb begin
        ptr_d  = ptr_q;
        we_d   = 1'b0;
        addr_d = addr_q;
        data_d = data_q;
        gid_d  = gid_q;
        if (grant) begin
            we_d   = 1'b1;
            addr_d = i_req_addr[win];
            data_d = i_req_data[win];
            gid_d  = win;
            ptr_d  = (win == GID_W'(NUM_REQ-1)) ? '0 : win + GID_W'(1);
        end
    end

    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            ptr_q  <= '0;
            we_q   <= 1'b0;
            addr_q <= '0;
            data_q <= '0;
            gid_q  <= '0;
        end else begin
            ptr_q  <= ptr_d;
            we_q   <= we_d;
            addr_q <= addr_d;
            data_q <= data_d;
            gid_q  <= gid_d;
        end
    end

    assign o_write_enable = we_q;
    assign o_write_addr   = addr_q;
    assign o_write_data   = data_q;
    assign o_grant_id     = gid_q;

`ifdef VEC_WB_HAZARD_EN
    // The write lands at the next edge, so a same-cycle read of that index is stale.
    assign o_hazard_a = we_q && (addr_q == i_rd_addr_a);
    assign o_hazard_b = we_q && (addr_q == i_rd_addr_b);
`else
    assign o_hazard_a = 1'b0;
    assign o_hazard_b = 1'b0;
`endif

endmodule

// File: tb/tb_vec_wb_arbiter.sv
// Scoreboard bench for vec_wb_arbiter: predicts grants, queues expected writes,
// compares them against the output stage and an emulated vec_ram.
module tb_vec_wb_arbiter;
    localparam int VS = 32;
    localparam int AW = 3;
    localparam int NR = 2;
    localparam int GW = 1;
    localparam int DW = 16 * VS;
    localparam int QW = GW + AW + DW;

    logic                          i_clk;
    logic                          i_rst;
    logic                          i_hold;
    logic [NR-1:0]                 i_req_valid;
    logic [NR-1:0]                 o_req_ready;
    logic [NR-1:0][AW-1:0]         i_req_addr;
    logic [NR-1:0][15:0][VS-1:0]   i_req_data;
    logic                          o_write_enable;
    logic [AW-1:0]                 o_write_addr;
    logic [15:0][VS-1:0]           o_write_data;
    logic [GW-1:0]                 o_grant_id;
    logic [AW-1:0]                 i_rd_addr_a;
    logic [AW-1:0]                 i_rd_addr_b;
    logic                          o_hazard_a;
    logic                          o_hazard_b;

    vec_wb_arbiter #(.VEC_SIZE(VS), .VEC_INDEX_WIDTH(AW), .NUM_REQ(NR)) dut (
        .i_clk(i_clk), .i_rst(i_rst), .i_hold(i_hold),
        .i_req_valid(i_req_valid), .o_req_ready(o_req_ready),
        .i_req_addr(i_req_addr), .i_req_data(i_req_data),
        .o_write_enable(o_write_enable), .o_write_addr(o_write_addr),
        .o_write_data(o_write_data), .o_grant_id(o_grant_id),
        .i_rd_addr_a(i_rd_addr_a), .i_rd_addr_b(i_rd_addr_b),
        .o_hazard_a(o_hazard_a), .o_hazard_b(o_hazard_b)
    );

    // clock / reset
    initial begin
        i_clk = 1'b0;
        forever #5 i_clk = ~i_clk;
    end

    logic [QW-1:0]       exp_q[$];
    logic [15:0][VS-1:0] tb_mem [2**AW];
    logic [GW-1:0]       m_ptr;
    logic                exp_we;
    int                  total;
    int                  bad;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [15:0][VS-1:0] rand_vec();
        logic [15:0][VS-1:0] v;
        for (int l = 0; l < 16; l++) v[l] = $urandom;
        return v;
    endfunction

    task automatic check_reset_outputs();
        check("rst_we", 32'(o_write_enable), 32'd0);
        check("rst_addr", 32'(o_write_addr), 32'd0);
        check("rst_gid", 32'(o_grant_id), 32'd0);
        check("rst_ready", 32'(o_req_ready), 32'd0);
        check("rst_haz_a", 32'(o_hazard_a), 32'd0);
        check("rst_haz_b", 32'(o_hazard_b), 32'd0);
        for (int l = 0; l < 16; l++) check("rst_data", o_write_data[l], 32'd0);
    endtask

    // One clock: check at negedge, update the model, return at posedge+1.
    task automatic step(output logic acc, output logic [GW-1:0] gnt);
        logic [NR-1:0] er;
        logic [QW-1:0] e;
        logic          ha, hb;
        int            idx;
        @(negedge i_clk);
        er = '0; acc = 1'b0; gnt = '0; ha = 1'b0; hb = 1'b0;
        if (!i_hold) begin
            for (int k = 0; k < NR; k++) begin
                idx = (int'(m_ptr) + k) % NR;
                if (!acc && i_req_valid[idx]) begin
                    acc = 1'b1;
                    gnt = GW'(idx);
                end
            end
        end
        if (acc) er[gnt] = 1'b1;
        check("ready", 32'(o_req_ready), 32'(er));
        check("we", 32'(o_write_enable), 32'(exp_we));
        if (exp_we) begin
            if (exp_q.size() == 0) begin
                check("q_underflow", 32'd1, 32'd0);
            end else begin
                e = exp_q.pop_front();
                check("gid", 32'(o_grant_id), 32'(e[QW-1 -: GW]));
                check("addr", 32'(o_write_addr), 32'(e[DW +: AW]));
                for (int l = 0; l < 16; l++) check("data", o_write_data[l], e[l*VS +: VS]);
`ifdef VEC_WB_HAZARD_EN
                ha = (e[DW +: AW] == i_rd_addr_a);
                hb = (e[DW +: AW] == i_rd_addr_b);
`endif
            end
        end
        check("haz_a", 32'(o_hazard_a), 32'(ha));
        check("haz_b", 32'(o_hazard_b), 32'(hb));
        if (o_write_enable) tb_mem[o_write_addr] = o_write_data;
        if (acc) begin
            exp_q.push_back({gnt, i_req_addr[gnt], i_req_data[gnt]});
            m_ptr = (int'(gnt) == NR - 1) ? '0 : gnt + GW'(1);
        end
        exp_we = acc;
        @(posedge i_clk);
        #1;
    endtask

    initial begin
        logic              acc;
        logic [GW-1:0]     gnt;
        logic [15:0][VS-1:0] vb;
        total = 0; bad = 0;
        m_ptr = '0; exp_we = 1'b0;
        for (int a = 0; a < 2**AW; a++) tb_mem[a] = '0;
        i_rst = 1'b0; i_hold = 1'b0; i_req_valid = '1;
        i_req_addr = '0; i_req_data = '0;
        i_rd_addr_a = 3'd7; i_rd_addr_b = 3'd7;
        repeat (2) @(posedge i_clk);
        #2;
        check_reset_outputs();
        i_req_valid = '0;
        @(posedge i_clk); #1;
        i_rst = 1'b1;

        // single requester, addr 3, lane i = i
        i_req_valid = 2'b01; i_req_addr[0] = 3'd3;
        for (int l = 0; l < 16; l++) i_req_data[0][l] = l;
        step(acc, gnt);
        check("t2_acc", 32'(acc), 32'd1);
        i_req_valid = '0;
        step(acc, gnt);
        step(acc, gnt);
        for (int l = 0; l < 16; l++) check("t2_mem3", tb_mem[3][l], 32'(l));

        // reset mid-transfer
        i_req_valid = 2'b11;
        i_req_addr[0] = 3'd1; i_req_addr[1] = 3'd6;
        i_req_data[0] = rand_vec(); i_req_data[1] = rand_vec();
        step(acc, gnt);
        #2 i_rst = 1'b0;
        #1 check_reset_outputs();
        exp_q.delete(); m_ptr = '0; exp_we = 1'b0;
        @(posedge i_clk); #1;
        i_rst = 1'b1;

        // both valid: strict rotation from pointer 0
        for (int k = 0; k < 4; k++) begin
            step(acc, gnt);
            check("rot_gnt", 32'(gnt), 32'(k % 2));
            i_req_data[gnt] = rand_vec();
            i_req_addr[gnt] = AW'($urandom_range(0, 7));
        end
        i_req_valid = '0;
        step(acc, gnt);
        step(acc, gnt);

        // same index from both requesters: later grant wins
        i_req_valid = 2'b11;
        i_req_addr[0] = 3'd5; i_req_addr[1] = 3'd5;
        i_req_data[0] = rand_vec(); vb = rand_vec(); i_req_data[1] = vb;
        step(acc, gnt);
        check("t4_first", 32'(gnt), 32'd0);
        i_req_valid = 2'b10;
        step(acc, gnt);
        check("t4_second", 32'(gnt), 32'd1);
        i_req_valid = '0;
        step(acc, gnt);
        step(acc, gnt);
        for (int l = 0; l < 16; l++) check("t4_mem5", tb_mem[5][l], vb[l]);

        // hold freezes arbitration; pointer survives it
        i_req_valid = 2'b01; i_req_data[0] = rand_vec();
        step(acc, gnt);
        i_req_valid = 2'b11; i_hold = 1'b1;
        i_req_data[0] = rand_vec(); i_req_data[1] = rand_vec();
        repeat (3) step(acc, gnt);
        i_hold = 1'b0;
        step(acc, gnt);
        check("t5_resume", 32'(gnt), 32'd1);
        i_req_valid = '0;
        step(acc, gnt);
        step(acc, gnt);

        // hazard window: write to 2 in flight, read ports at 2 and 4
        i_req_valid = 2'b01; i_req_addr[0] = 3'd2; i_req_data[0] = rand_vec();
        i_rd_addr_a = 3'd2; i_rd_addr_b = 3'd4;
        step(acc, gnt);
        i_req_valid = '0;
        step(acc, gnt);
        step(acc, gnt);

        // random traffic respecting the hold-until-accepted rule
        for (int c = 0; c < 300; c++) begin
            for (int r = 0; r < NR; r++) begin
                if (!i_req_valid[r] && $urandom_range(0, 1) == 1) begin
                    i_req_valid[r] = 1'b1;
                    i_req_addr[r]  = AW'($urandom_range(0, 7));
                    i_req_data[r]  = rand_vec();
                end
            end
            i_hold = ($urandom_range(0, 7) == 0);
            i_rd_addr_a = AW'($urandom_range(0, 7));
            i_rd_addr_b = AW'($urandom_range(0, 7));
            step(acc, gnt);
            if (acc) begin
                i_req_valid[gnt] = ($urandom_range(0, 2) != 0);
                i_req_addr[gnt]  = AW'($urandom_range(0, 7));
                i_req_data[gnt]  = rand_vec();
            end
        end
        i_req_valid = '0; i_hold = 1'b0;
        step(acc, gnt);
        step(acc, gnt);
        check("q_drained", 32'(exp_q.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
